// File: rtl/fre_lst_if.sv
// Free-list port bundle: release lanes and allocation slots between rename and fre_lst.
// Latency: none (wires only).
// Backpressure: none here; the slave raises alc_stl when a request cannot be granted.
interface fre_lst_if #(
    parameter int ISQ_DEPTH = 64,
    parameter int PREG_NUM  = 64,
    parameter int INST_PORT = 4
);
    localparam int PREG_W = $clog2(PREG_NUM);
    localparam int ENT_W  = PREG_W + 1;
    localparam int CNT_W  = $clog2(PREG_NUM + 1);

    logic [ISQ_DEPTH*ENT_W-1:0] fre_preg_in_flat;
    logic                       fre_en;
    logic [INST_PORT-1:0]       alc_req;
    logic [INST_PORT-1:0]       alc_vld;
    logic [INST_PORT*ENT_W-1:0] alc_preg_flat;
    logic                       alc_stl;
    logic [CNT_W-1:0]           fre_cnt;
    logic                       dbl_fre_err;

    modport master (
        output fre_preg_in_flat, fre_en, alc_req,
        input  alc_vld, alc_preg_flat, alc_stl, fre_cnt, dbl_fre_err
    );

    modport slave (
        input  fre_preg_in_flat, fre_en, alc_req,
        output alc_vld, alc_preg_flat, alc_stl, fre_cnt, dbl_fre_err
    );
endinterface

// File: rtl/fre_lst.sv
// Physical-register free list: bitmap allocator, lowest-free-first, all-or-nothing grants; FRE_LST_CHK_EN adds double-free check.
// Latency: grants are combinational from registered state; frees and grants land in the map at the next edge.
// Backpressure: alc_stl=1 (no slot granted) when requested count exceeds free count.
module fre_lst #(
    parameter int ISQ_DEPTH    = 64,
    parameter int PREG_NUM     = 64,
    parameter int INST_PORT    = 4,
    parameter int ARCH_REG_NUM = 16
) (
    input  logic     clk,
    input  logic     rst,
    fre_lst_if.slave bus
);
    localparam int PREG_W = $clog2(PREG_NUM);
    localparam int ENT_W  = PREG_W + 1;
    localparam int CNT_W  = $clog2(PREG_NUM + 1);
    localparam logic [PREG_NUM-1:0] RST_MAP =
        {{(PREG_NUM-ARCH_REG_NUM){1'b1}}, {ARCH_REG_NUM{1'b0}}};
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(PREG_NUM - ARCH_REG_NUM);

    logic [PREG_NUM-1:0] r_fre_map;
    logic [CNT_W-1:0]    r_fre_cnt;

    logic [PREG_NUM-1:0] w_rel_map;
    logic [CNT_W-1:0]    w_req_cnt;
    logic [PREG_NUM-1:0] w_avail;
    logic [PREG_W-1:0]   w_pick [INST_PORT];
    logic [INST_PORT-1:0] w_hit;
    logic                w_fit;
    logic                w_grant;
    logic [PREG_NUM-1:0] w_gnt_map;
    logic [PREG_NUM-1:0] w_nxt_map;
    logic [CNT_W-1:0]    w_nxt_cnt;

    // Duplicate lanes naturally collapse onto one bit of the release map.
    always_comb begin
        w_rel_map = '0;
        if (bus.fre_en) begin
            for (int l = 0; l < ISQ_DEPTH; l++) begin
                if (bus.fre_preg_in_flat[l*ENT_W+PREG_W]) begin
                    w_rel_map[bus.fre_preg_in_flat[l*ENT_W +: PREG_W]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_req_cnt = '0;
        for (int s = 0; s < INST_PORT; s++) begin
            w_req_cnt = w_req_cnt + CNT_W'(bus.alc_req[s]);
        end
    end

    // Slot-ordered priority chain: each requesting slot takes the lowest bit left by lower slots.
    always_comb begin
        w_avail = r_fre_map;
        w_hit   = '0;
        for (int s = 0; s < INST_PORT; s++) begin
            w_pick[s] = '0;
        end
        for (int s = 0; s < INST_PORT; s++) begin
            if (bus.alc_req[s]) begin
                for (int p = 0; p < PREG_NUM; p++) begin
                    if (!w_hit[s] && w_avail[p]) begin
                        w_pick[s] = PREG_W'(p);
                        w_hit[s]  = 1'b1;
                    end
                end
                if (w_hit[s]) begin
                    w_avail[w_pick[s]] = 1'b0;
                end
            end
        end
    end

    assign w_fit     = (w_req_cnt <= r_fre_cnt);
    assign w_grant   = !rst && w_fit;
    assign w_gnt_map = w_grant ? (r_fre_map & ~w_avail) : '0;

    assign bus.alc_vld = w_grant ? bus.alc_req : '0;
    assign bus.alc_stl = !rst && (|bus.alc_req) && !w_fit;

    always_comb begin
        bus.alc_preg_flat = '0;
        for (int s = 0; s < INST_PORT; s++) begin
            if (w_grant && bus.alc_req[s]) begin
                bus.alc_preg_flat[s*ENT_W +: ENT_W] = {1'b1, w_pick[s]};
            end
        end
    end

    // Release wins over a same-cycle grant of the same preg.
    assign w_nxt_map = (r_fre_map & ~w_gnt_map) | w_rel_map;

    always_comb begin
        w_nxt_cnt = '0;
        for (int p = 0; p < PREG_NUM; p++) begin
            w_nxt_cnt = w_nxt_cnt + CNT_W'(w_nxt_map[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fre_map <= RST_MAP;
            r_fre_cnt <= RST_CNT;
        end else begin
            r_fre_map <= w_nxt_map;
            r_fre_cnt <= w_nxt_cnt;
        end
    end

    assign bus.fre_cnt = r_fre_cnt;

`ifdef FRE_LST_CHK_EN
    logic r_dbl_fre_err;
    logic w_dbl_hit;

    assign w_dbl_hit = |(w_rel_map & r_fre_map & ~w_gnt_map);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbl_fre_err <= 1'b0;
        end else begin
            r_dbl_fre_err <= r_dbl_fre_err | w_dbl_hit;
        end
    end

    assign bus.dbl_fre_err = r_dbl_fre_err;
`else
    assign bus.dbl_fre_err = 1'b0;
`endif
endmodule
